seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised multi-digit seven-segment display controller with an addressed write port.
- Holds NUM_DIGITS hex digits, each with its own decimal point and enable flag.
- Time-multiplexes the digits onto one shared active-low segment bus and active-low anodes.
- Successor to the fixed 8-digit display top: adds configurable digit count, configurable scan rate, per-digit DP and enable, synchronous clear, and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (2..16).
- SEL_W, $clog2(NUM_DIGITS), width of the write address.
- REFRESH_DIV, 100000, clock cycles each digit is held active (>=1).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- write, input, 1, write strobe; sampled every rising edge.
- sel, input, SEL_W, digit address for the write.
- num, input, 4, hex value written to digit sel.
- dp_in, input, 1, decimal-point value written to digit sel (1 = lit).
- clear, input, 1, synchronous clear of all digit registers.
- seg, output, 7, segments active-low; seg[6]=A … seg[0]=G.
- dp, output, 1, decimal point, active-low.
- an, output, NUM_DIGITS, anodes active-low; an[i] drives digit i.
- scan_idx, output, SEL_W, index of the digit currently driven.

Behaviour:
- Reset (rst=0, asynchronous):
  - All digit values and DP bits become 0; all enable flags become 0.
  - Refresh counter and scan_idx become 0.
  - Outputs go to all-off: an all 1s, seg=7'h7F, dp=1.
- Write:
  - On a rising edge with write=1 and sel<NUM_DIGITS: val[sel]<=num, dpr[sel]<=dp_in, en[sel]<=1.
  - sel>=NUM_DIGITS: write ignored, no state change.
- Clear:
  - clear=1 sets all val, dpr and en to 0 on the next edge.
  - clear and write in the same cycle: clear wins and the write is dropped.
- Refresh counter:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - When cnt==REFRESH_DIV-1, scan_idx advances by 1; at NUM_DIGITS-1 it wraps to 0.
  - With REFRESH_DIV=1, scan_idx advances every cycle.
  - Counter runs continuously, independent of write and clear.
- Output stage:
  - an, seg and dp are registered from the current scan_idx and that digit's registers, so they lag scan_idx by 1 cycle.
  - Write-to-display latency is 2 cycles when the written digit is being scanned.
  - Exactly one an bit is low when the scanned digit is enabled; all an bits are high when the scanned digit is disabled. seg=7'h7F and dp=1 in that case.
- Decoder, active-low {A..G}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - dp = ~dpr[scan_idx].
- Reset asserted mid-scan immediately forces the all-off outputs. After release, scanning restarts at digit 0 with cnt=0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: an enabled digit i>0 whose value is 0 is blanked (an[i]=1, seg=7'h7F, dp=1) when every enabled digit above i also holds 0. DP does not prevent blanking. Digit 0 is never blanked by this rule.
- Undefined: all enabled digits display their value, zeros included.

Test Plan (NUM_DIGITS=8, REFRESH_DIV=4):
- Reset check: hold rst=0 then release → an=8'hFF, seg=7'h7F, dp=1, scan_idx=0. scan_idx reaches 1 after 4 cycles and wraps to 0 after 32 cycles.
- Write and display: write num=1..8 to sel=0..7 (dp_in=1 for sel=3 only), then scan a full frame → each slot shows an[i]=0 with the others 1. seg=1001111 for digit 0 and 0000000 for digit 7; dp=0 only in slot 3.
- Latency: with the scan parked in digit 2's slot, write num=F to sel=2 → seg=0111000 exactly 2 cycles after the write edge.
- Clear priority: write=1, sel=5, num=9 with clear=1 in the same cycle → next frame shows an=8'hFF in every slot and en[5] stays 0.
- Mid-scan reset: pull rst=0 at scan_idx=5, cnt=2 → outputs go all-off asynchronously; after release the first active slot is digit 0.
- LEADING_ZERO_BLANK_EN defined: write digits 7..0 = 0,0,0,0,0,1,2,0 → slots 7..3 show an high, slots 2..0 are lit. With the macro undefined all eight slots are lit.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed NUM_DIGITS-digit seven-segment controller with addressed write port
//   Optional build macro: LEADING_ZERO_BLANK_EN (blanks enabled leading zeros above digit 0)
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active low
//   write    : write strobe; stores num/dp_in into digit sel and enables it
//   sel      : digit address for the write (ignored when >= NUM_DIGITS)
//   num      : hex value to store
//   dp_in    : decimal-point value to store (1 = lit)
//   clear    : synchronous clear of all digit registers; beats a same-cycle write
//   seg      : segments {A..G}, active low
//   dp       : decimal point, active low
//   an       : anodes, active low, an[i] drives digit i
//   scan_idx : digit currently being scanned (outputs lag it by one cycle)
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS  = 8,
   parameter int SEL_W       = $clog2(NUM_DIGITS),
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write,
   input  logic [SEL_W-1:0]      sel,
   input  logic [3:0]            num,
   input  logic                  dp_in,
   input  logic                  clear,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an,
   output logic [SEL_W-1:0]      scan_idx
);
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   logic [CNT_W-1:0]            r_cnt;
   logic [SEL_W-1:0]            r_scan;
   logic [NUM_DIGITS-1:0][3:0]  r_val;
   logic [NUM_DIGITS-1:0]       r_dpr;
   logic [NUM_DIGITS-1:0]       r_en;
   logic [NUM_DIGITS-1:0]       w_blank;
   logic [6:0]                  w_seg;
   logic                        w_cnt_wrap;
   logic                        w_sel_ok;
   logic                        w_on;
   assign w_cnt_wrap = r_cnt == CNT_W'(REFRESH_DIV - 1);
   assign scan_idx   = r_scan;
   // a full power-of-two address space has no out-of-range selects
   generate
      if (NUM_DIGITS == (1 << SEL_W)) begin : g_sel_full
         assign w_sel_ok = 1'b1;
      end else begin : g_sel_part
         assign w_sel_ok = sel < SEL_W'(NUM_DIGITS);
      end
   endgenerate
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_cnt  <= '0;
         r_scan <= '0;
      end else begin
         r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
         if (w_cnt_wrap)
            r_scan <= (r_scan == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_scan + 1'b1;
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_val <= '0;
         r_dpr <= '0;
         r_en  <= '0;
      end else if (clear) begin
         r_val <= '0;
         r_dpr <= '0;
         r_en  <= '0;
      end else if (write && w_sel_ok) begin
         r_val[sel] <= num;
         r_dpr[sel] <= dp_in;
         r_en[sel]  <= 1'b1;
      end
`ifdef LEADING_ZERO_BLANK_EN
   // walk from the top digit down, remembering whether any enabled nonzero digit was seen
   always_comb begin
      logic nz;
      w_blank = '0;
      nz      = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         w_blank[i] = r_en[i] && (r_val[i] == 4'd0) && !nz;
         nz         = nz || (r_en[i] && (r_val[i] != 4'd0));
      end
   end
`else
   assign w_blank = '0;
`endif
   assign w_on = r_en[r_scan] && !w_blank[r_scan];
   always_comb begin
      w_seg = 7'h7F;
      case (r_val[r_scan])
         4'h0: w_seg = 7'b0000001;
         4'h1: w_seg = 7'b1001111;
         4'h2: w_seg = 7'b0010010;
         4'h3: w_seg = 7'b0000110;
         4'h4: w_seg = 7'b1001100;
         4'h5: w_seg = 7'b0100100;
         4'h6: w_seg = 7'b0100000;
         4'h7: w_seg = 7'b0001111;
         4'h8: w_seg = 7'b0000000;
         4'h9: w_seg = 7'b0000100;
         4'hA: w_seg = 7'b0001000;
         4'hB: w_seg = 7'b1100000;
         4'hC: w_seg = 7'b0110001;
         4'hD: w_seg = 7'b1000010;
         4'hE: w_seg = 7'b0110000;
         4'hF: w_seg = 7'b0111000;
         default: w_seg = 7'h7F;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         an  <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= ~(NUM_DIGITS'(w_on) << r_scan);
         seg <= w_on ? w_seg : 7'h7F;
         dp  <= ~(w_on && r_dpr[r_scan]);
      end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl (8 digits, 4-cycle refresh)
module tb_seg7_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       write = 1'b0;
   logic [2:0] sel = '0;
   logic [3:0] num = '0;
   logic       dp_in = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] an;
   logic [2:0] scan_idx;
   int vec = 0;
   int err = 0;
   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   seg7_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .write(write), .sel(sel), .num(num), .dp_in(dp_in),
      .clear(clear), .seg(seg), .dp(dp), .an(an), .scan_idx(scan_idx)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_scan(input int k);
      int n = 0;
      while (scan_idx !== 3'(k) && n < 64) begin
         tick();
         n++;
      end
      if (n == 64) begin
         vec++;
         err++;
         $display("FAIL wait_scan: scan_idx=%0d never reached %0d", scan_idx, k);
      end
   endtask
   task automatic write_digit(input int s, input int v, input logic d);
      write = 1'b1;
      sel   = 3'(s);
      num   = 4'(v);
      dp_in = d;
      tick();
      write = 1'b0;
      dp_in = 1'b0;
   endtask
   task automatic test_reset();
      #23;
      vec++; if (an !== 8'hFF) begin err++; $display("FAIL reset_an: got %h want ff", an); end
      vec++; if (seg !== 7'h7F) begin err++; $display("FAIL reset_seg: got %b want 1111111", seg); end
      vec++; if (dp !== 1'b1) begin err++; $display("FAIL reset_dp: got %b want 1", dp); end
      tick();
      rst = 1'b1;
      vec++; if (scan_idx !== 3'd0) begin err++; $display("FAIL reset_scan: got %0d want 0", scan_idx); end
      repeat (3) tick();
      vec++; if (scan_idx !== 3'd0) begin err++; $display("FAIL scan_hold3: got %0d want 0", scan_idx); end
      tick();
      vec++; if (scan_idx !== 3'd1) begin err++; $display("FAIL scan_step4: got %0d want 1", scan_idx); end
      repeat (27) tick();
      vec++; if (scan_idx !== 3'd7) begin err++; $display("FAIL scan_31: got %0d want 7", scan_idx); end
      tick();
      vec++; if (scan_idx !== 3'd0) begin err++; $display("FAIL scan_wrap32: got %0d want 0", scan_idx); end
      vec++; if (an !== 8'hFF) begin err++; $display("FAIL idle_an: got %h want ff", an); end
   endtask
   task automatic test_write_display();
      for (int i = 0; i < 8; i++) write_digit(i, i + 1, i == 3);
      for (int k = 0; k < 8; k++) begin
         wait_scan(k);
         tick();
         vec++; if (an !== ~(8'd1 << k)) begin err++; $display("FAIL disp_an[%0d]: got %h want %h", k, an, ~(8'd1 << k)); end
         vec++; if (seg !== seg_tab[k + 1]) begin err++; $display("FAIL disp_seg[%0d]: got %b want %b", k, seg, seg_tab[k + 1]); end
         vec++; if (dp !== (k != 3)) begin err++; $display("FAIL disp_dp[%0d]: got %b want %b", k, dp, k != 3); end
      end
   endtask
   task automatic test_latency();
      wait_scan(1);
      wait_scan(2);
      write = 1'b1;
      sel   = 3'd2;
      num   = 4'hF;
      dp_in = 1'b0;
      tick();
      write = 1'b0;
      vec++; if (seg !== 7'b0000110) begin err++; $display("FAIL lat_early: got %b want 0000110", seg); end
      tick();
      vec++; if (seg !== 7'b0111000) begin err++; $display("FAIL lat_seg: got %b want 0111000", seg); end
      vec++; if (an !== 8'hFB) begin err++; $display("FAIL lat_an: got %h want fb", an); end
   endtask
   task automatic test_clear_priority();
      write = 1'b1;
      clear = 1'b1;
      sel   = 3'd5;
      num   = 4'd9;
      tick();
      write = 1'b0;
      clear = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wait_scan(k);
         tick();
         vec++; if (an !== 8'hFF) begin err++; $display("FAIL clr_an[%0d]: got %h want ff", k, an); end
         vec++; if (seg !== 7'h7F) begin err++; $display("FAIL clr_seg[%0d]: got %b want 1111111", k, seg); end
         vec++; if (dp !== 1'b1) begin err++; $display("FAIL clr_dp[%0d]: got %b want 1", k, dp); end
      end
   endtask
   task automatic test_midscan_reset();
      write_digit(5, 5, 1'b1);
      wait_scan(4);
      wait_scan(5);
      tick();
      vec++; if (an !== 8'hDF) begin err++; $display("FAIL pre_rst_an: got %h want df", an); end
      tick();
      #2 rst = 1'b0;
      #1;
      vec++; if (an !== 8'hFF) begin err++; $display("FAIL arst_an: got %h want ff", an); end
      vec++; if (seg !== 7'h7F) begin err++; $display("FAIL arst_seg: got %b want 1111111", seg); end
      vec++; if (dp !== 1'b1) begin err++; $display("FAIL arst_dp: got %b want 1", dp); end
      vec++; if (scan_idx !== 3'd0) begin err++; $display("FAIL arst_scan: got %0d want 0", scan_idx); end
      repeat (2) tick();
      rst = 1'b1;
      write_digit(0, 0, 1'b0);
      tick();
      vec++; if (an !== 8'hFE) begin err++; $display("FAIL post_rst_an: got %h want fe", an); end
      vec++; if (seg !== 7'b0000001) begin err++; $display("FAIL post_rst_seg: got %b want 0000001", seg); end
      vec++; if (scan_idx !== 3'd0) begin err++; $display("FAIL post_rst_scan: got %0d want 0", scan_idx); end
   endtask
   task automatic test_leading_zero();
      int vals [8] = '{0, 2, 1, 0, 0, 0, 0, 0};
      logic lit;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 7; i >= 0; i--) write_digit(i, vals[i], 1'b0);
      for (int k = 0; k < 8; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
         lit = k < 3;
`else
         lit = 1'b1;
`endif
         wait_scan(k);
         tick();
         vec++; if (an !== (lit ? ~(8'd1 << k) : 8'hFF)) begin err++; $display("FAIL lzb_an[%0d]: got %h want %h", k, an, lit ? ~(8'd1 << k) : 8'hFF); end
         vec++; if (seg !== (lit ? seg_tab[vals[k]] : 7'h7F)) begin err++; $display("FAIL lzb_seg[%0d]: got %b want %b", k, seg, lit ? seg_tab[vals[k]] : 7'h7F); end
      end
   endtask
   initial begin
      test_reset();
      test_write_display();
      test_latency();
      test_clear_priority();
      test_midscan_reset();
      test_leading_zero();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
